// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: loads 16 words, then streams W_j / W'_j for j=0..63.
// Define SM3_EXPND_WP_EN to produce W'_j; otherwise expnd_w_p_o is tied 0.
module sm3_expnd_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pad_d_i,
  input  logic        pad_vld_i,
  input  logic        pad_lst_i,
  output logic        pad_ena_o,
  output logic [31:0] expnd_w_o,
  output logic [31:0] expnd_w_p_o,
  output logic [5:0]  expnd_j_o,
  output logic        expnd_vld_o,
  input  logic        expnd_rdy_i,
  output logic        expnd_lst_o
);

  typedef enum logic {LOAD, EXPND} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0][31:0]  win;
  logic [3:0]         ld_cnt;
  logic [5:0]         rnd_cnt;
  logic               blk_lst;
  logic               ld_acc;
  logic               rnd_acc;
  logic [31:0]        p1_in;
  logic [31:0]        p1_out;
  logic [31:0]        w_new;

  assign ld_acc  = pad_vld_i && pad_ena_o;
  assign rnd_acc = expnd_vld_o && expnd_rdy_i;

  // W_{j+16} from the window holding W_j..W_{j+15}
  assign p1_in  = win[0] ^ win[7] ^ {win[13][16:0], win[13][31:17]};
  assign p1_out = p1_in ^ {p1_in[16:0], p1_in[31:17]}
                ^ {p1_in[8:0], p1_in[31:9]};
  assign w_new  = p1_out ^ {win[3][24:0], win[3][31:25]} ^ win[10];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:  if (ld_acc && ld_cnt == 4'd15)   state_nxt = EXPND;
      EXPND: if (rnd_acc && rnd_cnt == 6'd63) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    pad_ena_o   = 1'b0;
    expnd_vld_o = 1'b0;
    expnd_w_o   = '0;
    expnd_w_p_o = '0;
    expnd_j_o   = '0;
    expnd_lst_o = 1'b0;
    unique case (state)
      LOAD: pad_ena_o = rst_n;
      EXPND: begin
        expnd_vld_o = 1'b1;
        expnd_w_o   = win[0];
`ifdef SM3_EXPND_WP_EN
        expnd_w_p_o = win[0] ^ win[4];
`else
        expnd_w_p_o = '0;
`endif
        expnd_j_o   = rnd_cnt;
        expnd_lst_o = blk_lst && (rnd_cnt == 6'd63);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win     <= '0;
      ld_cnt  <= '0;
      rnd_cnt <= '0;
      blk_lst <= 1'b0;
    end else if (ld_acc) begin
      win     <= {pad_d_i, win[15:1]};
      ld_cnt  <= ld_cnt + 4'd1;
      if (ld_cnt == 4'd15) blk_lst <= pad_lst_i;
    end else if (rnd_acc) begin
      win     <= {w_new, win[15:1]};
      rnd_cnt <= rnd_cnt + 6'd1;
      if (rnd_cnt == 6'd63) blk_lst <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Randomized bench for sm3_expnd_core against an array-based W_j model.
// Honours SM3_EXPND_WP_EN when building the expected W'_j.
module tb_sm3_expnd_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pad_d = '0;
  logic        pad_vld = 1'b0;
  logic        pad_lst = 1'b0;
  logic        rdy = 1'b0;
  logic        pad_ena;
  logic [31:0] w;
  logic [31:0] wp;
  logic [5:0]  j;
  logic        vld;
  logic        lst;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] blk [16];
  logic [31:0] mw  [68];
  logic [31:0] gold [6] = '{32'h9092e200, 32'h00000000, 32'h000c0606,
                            32'h719c70ed, 32'h00000000, 32'h8001801f};

  sm3_expnd_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pad_d_i     (pad_d),
    .pad_vld_i   (pad_vld),
    .pad_lst_i   (pad_lst),
    .pad_ena_o   (pad_ena),
    .expnd_w_o   (w),
    .expnd_w_p_o (wp),
    .expnd_j_o   (j),
    .expnd_vld_o (vld),
    .expnd_rdy_i (rdy),
    .expnd_lst_o (lst)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] p1(input logic [31:0] x);
    return x ^ rotl(x, 15) ^ rotl(x, 23);
  endfunction

  task automatic build_model();
    for (int k = 0; k < 16; k++) mw[k] = blk[k];
    for (int k = 16; k < 68; k++)
      mw[k] = p1(mw[k-16] ^ mw[k-9] ^ rotl(mw[k-3], 15))
            ^ rotl(mw[k-13], 7) ^ mw[k-6];
  endtask

  task automatic set_abc();
    for (int k = 0; k < 16; k++) blk[k] = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 16; k++) blk[k] = $urandom;
  endtask

  task automatic run_block(input int lst_idx, input bit rnd_vld,
                           input bit rnd_rdy, input bit abc);
    int wi = 0;
    int ri = 0;
    int cyc = 0;
    bit exp_vld;
    bit blk_lst = (lst_idx == 15);
    logic [31:0] exp_wp;
    build_model();
    while (ri < 64 && cyc < 2000) begin
      @(negedge clk);
      pad_vld = (wi < 16) && (rnd_vld ? ($urandom_range(0, 2) != 0) : 1'b1);
      pad_d   = (wi < 16) ? blk[wi] : $urandom;
      pad_lst = (wi == lst_idx);
      rdy     = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      exp_vld = (wi == 16);
      chk("pad_ena", pad_ena, !exp_vld);
      chk("vld", vld, exp_vld);
      if (exp_vld) begin
`ifdef SM3_EXPND_WP_EN
        exp_wp = mw[ri] ^ mw[ri+4];
`else
        exp_wp = '0;
`endif
        chk("j", j, ri);
        chk("w", w, mw[ri]);
        chk("w_p", wp, exp_wp);
        chk("lst", lst, blk_lst && ri == 63);
        if (abc && ri >= 16 && ri <= 21) chk("abc_w", w, gold[ri-16]);
`ifdef SM3_EXPND_WP_EN
        if (abc && ri == 0)  chk("abc_wp0", wp, 32'h61626380);
        if (abc && ri == 12) chk("abc_wp12", wp, 32'h9092e200);
`endif
        if (rdy) ri++;
      end else if (pad_vld) begin
        wi++;
      end
      cyc++;
    end
    if (ri < 64) chk("timeout_rounds", ri, 64);
    if (!rnd_vld && !rnd_rdy) chk("cycles", cyc, 80);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ena"}, pad_ena, 0);
    chk({tag, "_vld"}, vld, 0);
    chk({tag, "_w"}, w, 0);
    chk({tag, "_wp"}, wp, 0);
    chk({tag, "_j"}, j, 0);
    chk({tag, "_lst"}, lst, 0);
  endtask

  task automatic part_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pad_vld = 1'b1;
      pad_d   = $urandom;
      pad_lst = 1'b1;
      rdy     = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    pad_vld = 1'b0;
    pad_lst = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    set_abc();  run_block(15, 0, 0, 1);
    set_abc();  run_block(15, 0, 1, 1);
    set_rand(); run_block(7, 1, 1, 0);
    set_rand(); run_block(-1, 0, 0, 0);
    set_rand(); run_block(15, 0, 0, 0);
    part_reset(9);
    set_abc();  run_block(15, 0, 0, 1);
    part_reset(30);
    set_abc();  run_block(15, 1, 1, 1);
    for (int b = 0; b < 4; b++) begin
      set_rand();
      run_block($urandom_range(0, 15), 1, 1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sm3_expnd_core.md
SM3_EXPND_CORE -- requirements
Module: sm3_expnd_core

Interface
REQ-001 Parameters: none; data path fixed at 32-bit words.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; release synchronous to clk.
REQ-004 pad_d_i  input  32  padded message word from sm3_pad_core, big-endian word order within the 512-bit block.
REQ-005 pad_vld_i  input  1  pad_d_i valid.
REQ-006 pad_lst_i  input  1  word is the final word of the final block of the message.
REQ-007 pad_ena_o  output  1  ready to sm3_pad_core (drives its pad_otpt_ena_i); word accepted when pad_vld_i && pad_ena_o.
REQ-008 expnd_w_o  output  32  W_j.
REQ-009 expnd_w_p_o  output  32  W'_j = W_j ^ W_(j+4).
REQ-010 expnd_j_o  output  6  round index j, 0..63.
REQ-011 expnd_vld_o  output  1  outputs valid.
REQ-012 expnd_rdy_i  input  1  compression stage accepts round j when expnd_vld_o && expnd_rdy_i.
REQ-013 expnd_lst_o  output  1  high with j=63 of the final block only.

Function
REQ-014 States: LOAD, EXPND; reset state LOAD.
REQ-015 LOAD: pad_ena_o=1, expnd_vld_o=0; each accepted word shifts into a 16-entry window win[15:0] (win[0] oldest); 4-bit load counter increments.
REQ-016 On acceptance of 16th word: counter wraps to 0, pad_lst_i on that word latched into blk_lst, state -> EXPND; first round valid the next cycle (latency 1).
REQ-017 pad_lst_i on words 0..14 is ignored; blk_lst reflects only word 15.
REQ-018 EXPND: pad_ena_o=0, expnd_vld_o=1, expnd_w_o=win[0], expnd_w_p_o=win[0]^win[4], expnd_j_o=round counter.
REQ-019 On each accepted round: window shifts by one, win[15] <= P1(win[0]^win[7]^ROTL(win[13],15)) ^ ROTL(win[3],7) ^ win[10]; P1(x)=x^ROTL(x,15)^ROTL(x,23); round counter increments.
REQ-020 expnd_rdy_i low: window, counter and all outputs held stable; no round lost or duplicated.
REQ-021 Round 63 accepted: counter wraps to 0, state -> LOAD, pad_ena_o=1 the next cycle; blk_lst cleared.
REQ-022 expnd_lst_o = blk_lst && (j==63) && expnd_vld_o.
REQ-023 Window extension continues through round 63 so W_64..W_67 are available for W'_60..W'_63.
REQ-024 Per-block throughput: 16 load cycles + 64 round cycles, minimum 80 cycles with pad_vld_i and expnd_rdy_i constantly high.
REQ-025 All arithmetic modulo 2^32; rotations are 32-bit circular left.

Reset
REQ-026 rst_n low at any time, including mid-load or mid-expansion: state LOAD, counters 0, window 0, blk_lst 0, pad_ena_o 0 while in reset, expnd_vld_o 0, expnd_lst_o 0, expnd_w_o/expnd_w_p_o/expnd_j_o 0; partial block discarded.
REQ-027 First cycle after release: pad_ena_o=1.

Configuration
REQ-028 Macro SM3_EXPND_WP_EN (in sm3_cfg.v): defined -> expnd_w_p_o computed per REQ-018; undefined -> expnd_w_p_o tied 0 and the XOR logic removed; all other behaviour identical.

Verification
REQ-029 "abc" block (W0=61626380, W1..W14=0, W15=00000018, pad_lst_i on word 15), rdy=1 -> j=16..21 expnd_w_o = 9092e200, 00000000, 000c0606, 719c70ed, 00000000, 8001801f; j=0 expnd_w_p_o=61626380; j=12 expnd_w_p_o=9092e200; expnd_lst_o only at j=63.
REQ-030 Same block, expnd_rdy_i toggled pseudo-randomly -> identical 64-entry W/W' sequence as REQ-029, outputs stable while rdy low.
REQ-031 Two back-to-back blocks, pad_lst_i only on second block's word 15 -> expnd_lst_o low at first block j=63, high at second j=63; pad_ena_o low for exactly 64 accepted rounds between blocks.
REQ-032 pad_lst_i asserted on word 7 only -> ignored, expnd_lst_o never high.
REQ-033 rst_n pulsed low after 9 loaded words, then full "abc" block -> outputs match REQ-029 exactly.
REQ-034 SM3_EXPND_WP_EN undefined, "abc" block -> expnd_w_p_o=0 all rounds, expnd_w_o unchanged from REQ-029.
